div16_seq: RTL and testbench

DIV16_SEQ -- requirements
Module: div16_seq

---
 rtl/div16_seq.sv | 182 ++++++++++++++++++
 tb/tb_div16_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
// Sequential signed/unsigned 16-bit division wrapper around an external
// fixed-latency unsigned divider: sign handling, divide-by-zero and overflow.
module div16_seq #(
  parameter int unsigned DIV_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic [15:0] in_dividend,
  input  logic [15:0] in_divisor,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_quotient,
  output logic [15:0] out_remainder,
  output logic        out_div0,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(DIV_LAT);

  state_t      state;
  state_t      state_nxt;

  logic        accept;
  logic        sample_now;
  logic [3:0]  wait_cnt;

  // Operands captured at acceptance; the request bus is free to change after.
  logic        op_signed;
  logic        sign_a;
  logic        sign_b;
  logic [15:0] a_raw;
  logic [15:0] b_raw;
  logic [15:0] q_raw;
  logic [15:0] r_raw;

  logic        in_neg_a;
  logic        in_neg_b;
  logic [15:0] in_mag_a;
  logic [15:0] in_mag_b;

  logic [15:0] fix_q;
  logic [15:0] fix_r;
  logic        fix_div0;
  logic        fix_ovf;

  assign accept     = in_valid & in_ready;
  assign sample_now = (state == ST_WAIT) && (wait_cnt == 4'd1);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case keeps this process purely
  // combinational; any path leaving state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)         state_nxt = ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd1) state_nxt = ST_FIX;
      ST_FIX:                        state_nxt = ST_DONE;
      ST_DONE: if (out_ready)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // -------------------------------------------------------------------------
  // Operand magnitudes; |0x8000| wraps back to 0x8000, which the unsigned
  // divider interprets correctly as 32768.
  // -------------------------------------------------------------------------
  always_comb begin
    in_neg_a = in_signed & in_dividend[15];
    in_neg_b = in_signed & in_divisor[15];
    in_mag_a = in_neg_a ? (~in_dividend + 16'd1) : in_dividend;
    in_mag_b = in_neg_b ? (~in_divisor  + 16'd1) : in_divisor;
  end

  // -------------------------------------------------------------------------
  // Capture, divider operand registers, wait counter and divider sampling
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_signed    <= 1'b0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      a_raw        <= 16'd0;
      b_raw        <= 16'd0;
      div_dividend <= 16'd0;
      div_divisor  <= 16'd0;
      wait_cnt     <= 4'd0;
      q_raw        <= 16'd0;
      r_raw        <= 16'd0;
    end else if (accept) begin
      op_signed    <= in_signed;
      sign_a       <= in_neg_a;
      sign_b       <= in_neg_b;
      a_raw        <= in_dividend;
      b_raw        <= in_divisor;
      div_dividend <= in_mag_a;
      div_divisor  <= in_mag_b;
      wait_cnt     <= LAT_LOAD;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
      if (sample_now) begin
        q_raw <= div_quotient;
        r_raw <= div_remainder;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result fix-up: special cases first, then sign restoration so that the
  // quotient truncates toward zero and the remainder follows the dividend.
  // -------------------------------------------------------------------------
  always_comb begin
    fix_q    = q_raw;
    fix_r    = r_raw;
    fix_div0 = 1'b0;
    fix_ovf  = 1'b0;
    if (b_raw == 16'd0) begin
      fix_q    = 16'hFFFF;
      fix_r    = a_raw;
      fix_div0 = 1'b1;
    end else if (op_signed && (a_raw == 16'h8000) && (b_raw == 16'hFFFF)) begin
      fix_q   = 16'h8000;
      fix_r   = 16'h0000;
      fix_ovf = 1'b1;
    end else if (op_signed) begin
      if (sign_a ^ sign_b) fix_q = ~q_raw + 16'd1;
      if (sign_a)          fix_r = ~r_raw + 16'd1;
    end
  end

  // Result registers load only in FIX, so they hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_quotient  <= 16'd0;
      out_remainder <= 16'd0;
      out_div0      <= 1'b0;
      out_ovf       <= 1'b0;
    end else if (state == ST_FIX) begin
      out_quotient  <= fix_q;
      out_remainder <= fix_r;
      out_div0      <= fix_div0;
      out_ovf       <= fix_ovf;
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Directed bench for div16_seq: two instances (DIV_LAT 1 and 4) share the
// request bus; each has its own unsigned divider model with matching latency.
module tb_div16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_signed;
  logic [15:0] in_dividend;
  logic [15:0] in_divisor;
  logic        out_ready;

  logic        l1_in_ready, l1_out_valid, l1_out_div0, l1_out_ovf;
  logic [15:0] l1_div_dividend, l1_div_divisor, l1_div_quotient, l1_div_remainder;
  logic [15:0] l1_out_quotient, l1_out_remainder;

  logic        l4_in_ready, l4_out_valid, l4_out_div0, l4_out_ovf;
  logic [15:0] l4_div_dividend, l4_div_divisor, l4_div_quotient, l4_div_remainder;
  logic [15:0] l4_out_quotient, l4_out_remainder;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div16_seq #(.DIV_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l1_in_ready),
    .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(l1_div_dividend), .div_divisor(l1_div_divisor),
    .div_quotient(l1_div_quotient), .div_remainder(l1_div_remainder),
    .out_valid(l1_out_valid), .out_ready(out_ready),
    .out_quotient(l1_out_quotient), .out_remainder(l1_out_remainder),
    .out_div0(l1_out_div0), .out_ovf(l1_out_ovf)
  );

  div16_seq #(.DIV_LAT(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l4_in_ready),
    .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(l4_div_dividend), .div_divisor(l4_div_divisor),
    .div_quotient(l4_div_quotient), .div_remainder(l4_div_remainder),
    .out_valid(l4_out_valid), .out_ready(out_ready),
    .out_quotient(l4_out_quotient), .out_remainder(l4_out_remainder),
    .out_div0(l4_out_div0), .out_ovf(l4_out_ovf)
  );

  // Divider model; on a zero divisor it returns junk the DUT must ignore.
  function automatic logic [15:0] mdl_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hBEEF : a / b;
  endfunction

  function automatic logic [15:0] mdl_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hDEAD : a % b;
  endfunction

  assign l1_div_quotient  = mdl_q(l1_div_dividend, l1_div_divisor);
  assign l1_div_remainder = mdl_r(l1_div_dividend, l1_div_divisor);

  // Latency-4 divider: three register stages, so the result is only correct
  // on the edge DIV_LAT edges after the operands settle.
  logic [15:0] p4_q [3];
  logic [15:0] p4_r [3];
  always @(posedge clk) begin
    p4_q[0] <= mdl_q(l4_div_dividend, l4_div_divisor);
    p4_r[0] <= mdl_r(l4_div_dividend, l4_div_divisor);
    p4_q[1] <= p4_q[0];
    p4_r[1] <= p4_r[0];
    p4_q[2] <= p4_q[1];
    p4_r[2] <= p4_r[1];
  end
  assign l4_div_quotient  = p4_q[2];
  assign l4_div_remainder = p4_r[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/l1_in_ready"},  32'(l1_in_ready), 32'd1);
    check({tag, "/l1_out_valid"}, 32'(l1_out_valid), 32'd0);
    check({tag, "/l1_q"},         32'(l1_out_quotient), 32'd0);
    check({tag, "/l1_r"},         32'(l1_out_remainder), 32'd0);
    check({tag, "/l1_flags"},     32'({l1_out_div0, l1_out_ovf}), 32'd0);
    check({tag, "/l1_div_ops"},   {l1_div_dividend, l1_div_divisor}, 32'd0);
    check({tag, "/l4_in_ready"},  32'(l4_in_ready), 32'd1);
    check({tag, "/l4_out_valid"}, 32'(l4_out_valid), 32'd0);
    check({tag, "/l4_q"},         32'(l4_out_quotient), 32'd0);
    check({tag, "/l4_r"},         32'(l4_out_remainder), 32'd0);
    check({tag, "/l4_flags"},     32'({l4_out_div0, l4_out_ovf}), 32'd0);
    check({tag, "/l4_div_ops"},   {l4_div_dividend, l4_div_divisor}, 32'd0);
  endtask

  // Present one request for the acceptance edge, then scramble the bus.
  task automatic start_op(input logic sgn, input logic [15:0] a, input logic [15:0] b);
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    tick();
    in_valid    = 1'b0;
    in_signed   = ~sgn;
    in_dividend = 16'($urandom);
    in_divisor  = 16'($urandom);
  endtask

  // Called #1 after the acceptance edge; latencies are counted from it.
  task automatic wait_check(input string tag, input logic [15:0] da, input logic [15:0] db,
                            input logic [15:0] q, input logic [15:0] r,
                            input logic div0, input logic ovf);
    int cnt = 0;
    check({tag, "/l1_div_ops"}, {l1_div_dividend, l1_div_divisor}, {da, db});
    check({tag, "/l4_div_ops"}, {l4_div_dividend, l4_div_divisor}, {da, db});
    while (!l1_out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "/l1_latency"}, 32'(cnt), 32'd2);
    check({tag, "/l1_q"},       32'(l1_out_quotient), 32'(q));
    check({tag, "/l1_r"},       32'(l1_out_remainder), 32'(r));
    check({tag, "/l1_flags"},   32'({l1_out_div0, l1_out_ovf}), 32'({div0, ovf}));
    while (!l4_out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "/l4_latency"}, 32'(cnt), 32'd5);
    check({tag, "/l4_q"},       32'(l4_out_quotient), 32'(q));
    check({tag, "/l4_r"},       32'(l4_out_remainder), 32'(r));
    check({tag, "/l4_flags"},   32'({l4_out_div0, l4_out_ovf}), 32'({div0, ovf}));
    tick();
    check({tag, "/l4_released"}, 32'({l4_out_valid, l4_in_ready}), 32'b01);
  endtask

  typedef struct {
    string       tag;
    logic        sgn;
    logic [15:0] a, b, da, db, q, r;
    logic        div0, ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic seen;
    int   cnt;

    vecs.push_back('{"u100_7",     1'b0, 16'd100,  16'd7,    16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0});
    vecs.push_back('{"s_m7_2",     1'b1, 16'hFFF9, 16'h0002, 16'h0007, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{"s_7_m2",     1'b1, 16'h0007, 16'hFFFE, 16'h0007, 16'h0002, 16'hFFFD, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{"u1234_0",    1'b0, 16'h04D2, 16'h0000, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0});
    vecs.push_back('{"s1234_0",    1'b1, 16'h04D2, 16'h0000, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1'b0});
    vecs.push_back('{"s_ovf",      1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{"u_8000_ffff",1'b0, 16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0});
    vecs.push_back('{"s_min_3",    1'b1, 16'h8000, 16'h0003, 16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{"s_min_0",    1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1, 1'b0});
    vecs.push_back('{"u_ffff_16",  1'b0, 16'hFFFF, 16'h0010, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0});

    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_signed   = 1'b0;
    in_dividend = 16'd0;
    in_divisor  = 16'd0;
    out_ready   = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    tick();
    tick();
    rst_n = 1'b1;

    // First request goes on the first edge after reset release.
    foreach (vecs[i]) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_check(vecs[i].tag, vecs[i].da, vecs[i].db, vecs[i].q, vecs[i].r,
                 vecs[i].div0, vecs[i].ovf);
    end

    // Back-pressure: result held, new requests ignored, bus churning.
    in_signed   = 1'b0;
    in_dividend = 16'd1000;
    in_divisor  = 16'd10;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    tick();
    cnt = 0;
    while (!l4_out_valid && cnt < 20) begin
      in_signed   = 1'($urandom);
      in_dividend = 16'($urandom);
      in_divisor  = 16'($urandom);
      tick();
      cnt++;
    end
    check("hold/l4_latency", 32'(cnt), 32'd5);
    repeat (5) begin
      in_signed   = 1'($urandom);
      in_dividend = 16'($urandom);
      in_divisor  = 16'($urandom);
      tick();
      check("hold/valid",     32'({l1_out_valid, l4_out_valid}), 32'b11);
      check("hold/in_ready",  32'({l1_in_ready, l4_in_ready}), 32'b00);
      check("hold/l1_result", {l1_out_quotient, l1_out_remainder}, {16'd100, 16'd0});
      check("hold/l4_result", {l4_out_quotient, l4_out_remainder}, {16'd100, 16'd0});
      check("hold/l1_div_ops", {l1_div_dividend, l1_div_divisor}, {16'd1000, 16'd10});
    end
    in_signed   = 1'b0;
    in_dividend = 16'd50;
    in_divisor  = 16'd5;
    out_ready   = 1'b1;
    tick();
    check("release/in_ready",  32'({l1_in_ready, l4_in_ready}), 32'b11);
    check("release/valid",     32'({l1_out_valid, l4_out_valid}), 32'b00);
    check("release/no_bypass", {l1_div_dividend, l1_div_divisor}, {16'd1000, 16'd10});
    tick();
    in_valid    = 1'b0;
    in_dividend = 16'hA5A5;
    wait_check("after_hold", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0);

    // Reset while the latency-4 instance is still waiting on its divider.
    start_op(1'b1, 16'hFFF9, 16'h0002);
    tick();
    rst_n = 1'b0;
    #1 check_reset("rst_mid_op");
    tick();
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | l1_out_valid | l4_out_valid;
    end
    check("rst_mid_op/no_result", 32'(seen), 32'd0);
    start_op(1'b1, 16'hFF9C, 16'hFFF9);
    wait_check("post_rst", 16'd100, 16'd7, 16'h000E, 16'hFFFE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
